// File: rtl/dcache_sram_nway.sv
// N-way set-associative data-cache array: tag match, LRU replacement, write-back flush sweep.
// Latency: access results registered one cycle after req_i; flush visits one (set, way) per cycle.
// Backpressure: rdy_o drops for the whole flush; the sweep stalls on a dirty line until wb_ready_i.
//
// Ports:
//   clk_i, rst_i (async, active-high)
//   req_i, write_i, dirty_i, idx_i, tag_i, data_i      access request
//   rdy_o, hit_o, hit_way_o, data_o                    access result (held until the next access)
//   victim_valid_o/dirty_o/tag_o/data_o                line displaced by a write miss
//   flush_i, flush_busy_o                              write-back-and-invalidate sweep
//   wb_valid_o, wb_ready_i, wb_idx_o/tag_o/data_o      write-back handshake
module dcache_sram_nway #(
   parameter int SETS   = 16,
   parameter int WAYS   = 2,
   parameter int TAG_W  = 23,
   parameter int LINE_W = 256,
   localparam int IDX_W = $clog2(SETS),
   localparam int WAY_W = (WAYS > 2) ? $clog2(WAYS) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic              write_i,
   input  logic              dirty_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [TAG_W-1:0]  tag_i,
   input  logic [LINE_W-1:0] data_i,
   output logic              rdy_o,
   output logic              hit_o,
   output logic [WAY_W-1:0]  hit_way_o,
   output logic [LINE_W-1:0] data_o,
   output logic              victim_valid_o,
   output logic              victim_dirty_o,
   output logic [TAG_W-1:0]  victim_tag_o,
   output logic [LINE_W-1:0] victim_data_o,
   input  logic              flush_i,
   output logic              flush_busy_o,
   output logic              wb_valid_o,
   input  logic              wb_ready_i,
   output logic [IDX_W-1:0]  wb_idx_o,
   output logic [TAG_W-1:0]  wb_tag_o,
   output logic [LINE_W-1:0] wb_data_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_WB} state_t;

   // The sweep position is {set, way}; both sizes are powers of two, so a
   // plain increment walks set 0 way 0 .. set SETS-1 way WAYS-1.
   localparam int SCAN_W = IDX_W + WAY_W;

   logic [WAYS-1:0]   valid_q [SETS];
   logic [WAYS-1:0]   dirty_q [SETS];
   logic [WAY_W-1:0]  age_q   [SETS][WAYS];
   logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
   logic [LINE_W-1:0] data_q  [SETS][WAYS];

   state_t            state_q;
   logic [SCAN_W-1:0] scan_q;
   logic [IDX_W-1:0]  scan_set;
   logic [WAY_W-1:0]  scan_way;
   logic              scan_wb;
   logic              scan_retire;

   logic              acc_en;
   logic              acc_wr;
   logic              hit;
   logic [WAY_W-1:0]  hit_way;
   logic [WAY_W-1:0]  vic_way;
   logic [WAY_W-1:0]  acc_way;
   logic [WAY_W-1:0]  acc_age;
   logic              vic_vld;

   assign acc_en   = req_i && rdy_o;
   assign acc_wr   = acc_en && write_i;
   assign scan_set = scan_q[SCAN_W-1:WAY_W];
   assign scan_way = scan_q[WAY_W-1:0];
   assign scan_wb  = valid_q[scan_set][scan_way] && dirty_q[scan_set][scan_way];
   // An entry is retired (invalidated, sweep advances) either straight from
   // SCAN when it needs no write-back, or from WB once the handshake completes.
   assign scan_retire = (state_q == ST_SCAN && !scan_wb) || (state_q == ST_WB && wb_ready_i);

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[idx_i][w] && tag_q[idx_i][w] == tag_i) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
      // Oldest way first, then overridden by the lowest-index invalid way if any.
      vic_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (age_q[idx_i][w] == WAY_W'(WAYS - 1)) vic_way = WAY_W'(w);
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[idx_i][w]) vic_way = WAY_W'(w);
      end
      acc_way = hit ? hit_way : vic_way;
      acc_age = age_q[idx_i][acc_way];
      vic_vld = write_i && !hit && valid_q[idx_i][vic_way];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
         end
         state_q        <= ST_IDLE;
         scan_q         <= '0;
         rdy_o          <= 1'b1;
         flush_busy_o   <= 1'b0;
         hit_o          <= 1'b0;
         hit_way_o      <= '0;
         data_o         <= '0;
         victim_valid_o <= 1'b0;
         victim_dirty_o <= 1'b0;
         victim_tag_o   <= '0;
         victim_data_o  <= '0;
         wb_valid_o     <= 1'b0;
         wb_idx_o       <= '0;
         wb_tag_o       <= '0;
         wb_data_o      <= '0;
      end else begin
         if (acc_en) begin
            hit_o          <= hit;
            hit_way_o      <= (hit || write_i) ? acc_way : '0;
            data_o         <= hit ? data_q[idx_i][hit_way] : '0;
            victim_valid_o <= vic_vld;
            victim_dirty_o <= vic_vld && dirty_q[idx_i][vic_way];
            victim_tag_o   <= vic_vld ? tag_q[idx_i][vic_way] : '0;
            victim_data_o  <= vic_vld ? data_q[idx_i][vic_way] : '0;
            if (write_i) begin
               valid_q[idx_i][acc_way] <= 1'b1;
               dirty_q[idx_i][acc_way] <= dirty_i | (hit & dirty_q[idx_i][acc_way]);
            end
            // Move-to-front: only ways younger than the touched one age by one,
            // which keeps the ages a permutation.
            if (hit || write_i) begin
               for (int w = 0; w < WAYS; w++) begin
                  if (WAY_W'(w) == acc_way)
                     age_q[idx_i][w] <= '0;
                  else if (age_q[idx_i][w] < acc_age)
                     age_q[idx_i][w] <= age_q[idx_i][w] + WAY_W'(1);
               end
            end
         end

         case (state_q)
            ST_IDLE: begin
               if (flush_i) begin
                  state_q      <= ST_SCAN;
                  scan_q       <= '0;
                  rdy_o        <= 1'b0;
                  flush_busy_o <= 1'b1;
               end
            end
            ST_SCAN: begin
               if (scan_wb) begin
                  state_q    <= ST_WB;
                  wb_valid_o <= 1'b1;
                  wb_idx_o   <= scan_set;
                  wb_tag_o   <= tag_q[scan_set][scan_way];
                  wb_data_o  <= data_q[scan_set][scan_way];
               end
            end
            ST_WB:   ;
            default: state_q <= ST_IDLE;
         endcase

         if (scan_retire) begin
            valid_q[scan_set][scan_way] <= 1'b0;
            dirty_q[scan_set][scan_way] <= 1'b0;
            wb_valid_o                  <= 1'b0;
            scan_q                      <= scan_q + SCAN_W'(1);
            if (&scan_q) begin
               state_q      <= ST_IDLE;
               rdy_o        <= 1'b1;
               flush_busy_o <= 1'b0;
            end else begin
               state_q <= ST_SCAN;
            end
         end
      end
   end

   // Tag and data storage carry no reset; valid bits qualify them.
   always_ff @(posedge clk_i) begin
      if (acc_wr) begin
         tag_q[idx_i][acc_way]  <= tag_i;
         data_q[idx_i][acc_way] <= data_i;
      end
   end

endmodule

// File: doc/dcache_sram_nway.md
DCACHE_SRAM_NWAY -- requirements
Module: dcache_sram_nway

Interface
REQ-001 Parameter SETS, default 16: number of sets; power of two, 2..256; IDX_W = clog2(SETS).
REQ-002 Parameter WAYS, default 2: associativity; power of two, 2..8; WAY_W = max(1, clog2(WAYS)).
REQ-003 Parameter TAG_W, default 23: stored tag width.
REQ-004 Parameter LINE_W, default 256: cache line width in bits.
REQ-005 clk_i  in  1  clock; all state changes on the rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-high.
REQ-007 req_i  in  1  lookup/access strobe, one access per cycle.
REQ-008 write_i  in  1  with req_i: write the line (write-hit update, or miss fill).
REQ-009 dirty_i  in  1  dirty value stored with a write.
REQ-010 idx_i  in  IDX_W  set index.
REQ-011 tag_i  in  TAG_W  access tag.
REQ-012 data_i  in  LINE_W  write data.
REQ-013 rdy_o  out  1  high when accesses are accepted; low while flushing.
REQ-014 hit_o  out  1  registered hit result of the previous accepted access.
REQ-015 hit_way_o  out  WAY_W  way that hit, or way filled on a miss write.
REQ-016 data_o  out  LINE_W  line data of the hit way; 0 on a miss.
REQ-017 victim_valid_o, victim_dirty_o  out  1 each  state of the line evicted by a miss write.
REQ-018 victim_tag_o  out  TAG_W; victim_data_o  out  LINE_W  the evicted line's tag and data.
REQ-019 flush_i  in  1  pulse: start a write-back-and-invalidate sweep.
REQ-020 flush_busy_o  out  1  sweep in progress.
REQ-021 wb_valid_o  out  1; wb_ready_i  in  1  write-back handshake; transfer when both are high.
REQ-022 wb_idx_o  out  IDX_W; wb_tag_o  out  TAG_W; wb_data_o  out  LINE_W  write-back line.

Function
REQ-023 Per set and way, the block SHALL store valid, dirty, tag, data and a WAY_W-bit LRU age.
REQ-024 A hit is a way of set idx_i that is valid and whose tag equals tag_i; at most one way hits.
REQ-025 Access results SHALL appear one cycle after req_i and hold until the next accepted access.
REQ-026 Read hit: hit_o=1, data_o = the line; arrays are unchanged except for the LRU ages.
REQ-027 Write hit: the hit way's data is replaced and its dirty bit is ORed with dirty_i; hit_o=1; data_o = the old line.
REQ-028 Write miss: the victim is the lowest-index invalid way; if none is invalid, the way with age WAYS-1; it is written with valid=1, dirty=dirty_i, tag_i, data_i.
REQ-029 On a write miss, victim_* SHALL present the pre-replacement line state in the result cycle; victim_valid_o=0 if the victim way was invalid.
REQ-030 Read miss: hit_o=0, data_o=0, victim_valid_o=0; no state change.
REQ-031 LRU update on a hit or fill to way w with age a: way w becomes age 0; every way with age < a increments; other ways are unchanged; ages stay a permutation of 0..WAYS-1.
REQ-032 Back-to-back accesses to the same set SHALL see the prior cycle's write (no stale data).
REQ-033 Flush FSM states: IDLE -> SCAN (flush_i in IDLE, rdy_o=0); SCAN visits one (set, way) per cycle in order set 0 way 0 .. set SETS-1 way WAYS-1.
REQ-034 SCAN on a valid, dirty entry -> WB: wb_valid_o=1 with stable wb_idx/tag/data until wb_ready_i; then valid=dirty=0 -> SCAN at the next entry.
REQ-035 SCAN on other entries: valid=dirty=0, no handshake; after the last entry -> IDLE, and rdy_o=1 the next cycle.
REQ-036 flush_i while busy is ignored; req_i while rdy_o=0 is ignored; req_i and flush_i together in IDLE: the access is performed and the flush starts the next cycle.
REQ-037 LRU ages are untouched by a flush.

Reset
REQ-038 On rst_i, all valid/dirty SHALL clear, way w age = w, FSM -> IDLE, all outputs 0 except rdy_o=1; data/tag arrays need not reset.
REQ-039 Reset during a flush SHALL abort it immediately, with wb_valid_o=0 asynchronously.

Verification
REQ-040 Reset, read set 3 tag 0x5 -> hit_o=0, data_o=0, victim_valid_o=0.
REQ-041 Write set 3 tag 0x5 data A, dirty=1, then read -> fill way 0, victim_valid_o=0; then hit_o=1, hit_way_o=0, data_o=A.
REQ-042 WAYS=2: fill set 3 tags 0x5, 0x6; read 0x5; write-miss tag 0x7 -> victim way 1, victim_tag_o=0x6, victim_valid_o=1.
REQ-043 WAYS=4: fill 4 tags, touch ways 0, 2, 1 in order; miss-write -> victim way 3; then miss-write -> victim way 0.
REQ-044 Two dirty lines in sets 0 and 5; flush with wb_ready_i held low 3 cycles -> wb stable, exactly 2 transfers in set order, then all reads miss, rdy_o=1.
REQ-045 Assert rst_i during a WB wait -> wb_valid_o=0, flush_busy_o=0, all lines invalid.
